regfile_write_ctrl: RTL and testbench

- Write-side controller for the 4-entry x 32-bit register file. It queues writeback requests from the datapath and issues them in order onto the register file's single write port (RegWrite/WriteReg/WriteData).
- It also keeps a per-register pending-write scoreboard, so that read-side logic can stall on registers whose results are still outstanding.
- Sits between execute/memory writeback and the register file.

---
 rtl/regfile_write_ctrl.sv | 159 +++++++++++++++
 tb/tb_regfile_write_ctrl.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_write_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : regfile_write_ctrl
//  Purpose  : Write-side controller for a 4-entry x 32-bit register file.
//             Queues writeback requests in a circular FIFO and issues them in
//             order onto the single register-file write port. A per-register
//             pending-write scoreboard lets read-side logic stall on registers
//             whose results are still outstanding.
//  Ports    : clk, reset           - clock / synchronous active-high reset
//             req_*                - writeback request (valid/ready, reg, data)
//             rsv_*                - destination reservation (valid/ready, reg)
//             wr_hold              - register file write port unavailable
//             RegWrite/WriteReg/WriteData - register file write port
//             busy_mask            - per-register pending-write flags
//             sb_err               - sticky scoreboard underflow flag
//  Revision : 1.0 - initial release
// ============================================================================
module regfile_write_ctrl #(
    parameter int DEPTH = 4,
    parameter int CNTW  = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [1:0]  req_reg,
    input  logic [31:0] req_data,
    input  logic        rsv_valid,
    output logic        rsv_ready,
    input  logic [1:0]  rsv_reg,
    input  logic        wr_hold,
    output logic        RegWrite,
    output logic [1:0]  WriteReg,
    output logic [31:0] WriteData,
    output logic [3:0]  busy_mask,
    output logic        sb_err
);

    localparam int              PW        = $clog2(DEPTH);
    localparam logic [PW:0]     C_FULL    = (PW+1)'(DEPTH);
    localparam logic [CNTW-1:0] C_CNT_MAX = '1;

    // Queue state
    logic [PW-1:0]   wptr_q, wptr_d;
    logic [PW-1:0]   rptr_q, rptr_d;
    logic [PW:0]     count_q, count_d;
    logic [1:0]      reg_mem_q  [DEPTH];
    logic [1:0]      reg_mem_d  [DEPTH];
    logic [31:0]     data_mem_q [DEPTH];
    logic [31:0]     data_mem_d [DEPTH];

    // Scoreboard state
    logic [CNTW-1:0] pend_cnt_q [4];
    logic [CNTW-1:0] pend_cnt_d [4];
    logic            sb_err_q, sb_err_d;

    logic            w_not_empty;
    logic            w_push;
    logic            w_pop;
    logic            w_rsv;
    logic [3:0]      w_inc;
    logic [3:0]      w_dec;
    logic [3:0]      w_udf;

    // ------------------------------------------------------------------
    // Handshakes and issue port (head entry presented combinationally)
    // ------------------------------------------------------------------
    assign w_not_empty = (count_q != '0);
    assign req_ready   = (count_q != C_FULL) && !reset;
    assign RegWrite    = w_not_empty && !wr_hold && !reset;
    assign WriteReg    = (w_not_empty && !reset) ? reg_mem_q[rptr_q]  : 2'd0;
    assign WriteData   = (w_not_empty && !reset) ? data_mem_q[rptr_q] : 32'd0;
    assign rsv_ready   = (pend_cnt_q[rsv_reg] != C_CNT_MAX) && !reset;
    assign sb_err      = sb_err_q;

    assign w_push = req_valid && req_ready;
    assign w_pop  = RegWrite;
    assign w_rsv  = rsv_valid && rsv_ready;

    // ------------------------------------------------------------------
    // Per-register scoreboard events
    // ------------------------------------------------------------------
    generate
        for (genvar r = 0; r < 4; r++) begin : g_sb
            assign w_inc[r]     = w_rsv && (rsv_reg == 2'(r));
            assign w_dec[r]     = w_pop && (WriteReg == 2'(r));
            // A same-cycle reservation covers the commit, so no underflow.
            assign w_udf[r]     = w_dec[r] && !w_inc[r] && (pend_cnt_q[r] == '0);
            assign busy_mask[r] = (pend_cnt_q[r] != '0) && !reset;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        wptr_d     = wptr_q;
        rptr_d     = rptr_q;
        count_d    = count_q;
        reg_mem_d  = reg_mem_q;
        data_mem_d = data_mem_q;

        if (w_push) begin
            reg_mem_d[wptr_q]  = req_reg;
            data_mem_d[wptr_q] = req_data;
            wptr_d             = wptr_q + PW'(1);   // DEPTH is a power of 2: natural wrap
        end
        if (w_pop) begin
            rptr_d = rptr_q + PW'(1);
        end
        case ({w_push, w_pop})
            2'b10:   count_d = count_q + (PW+1)'(1);
            2'b01:   count_d = count_q - (PW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        sb_err_d = sb_err_q || (w_udf != 4'd0);
        for (int r = 0; r < 4; r++) begin
            pend_cnt_d[r] = pend_cnt_q[r];
            if (w_inc[r] && !w_dec[r]) begin
                pend_cnt_d[r] = pend_cnt_q[r] + CNTW'(1);
            end else if (w_dec[r] && !w_inc[r] && (pend_cnt_q[r] != '0)) begin
                pend_cnt_d[r] = pend_cnt_q[r] - CNTW'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            wptr_q   <= '0;
            rptr_q   <= '0;
            count_q  <= '0;
            sb_err_q <= 1'b0;
            for (int r = 0; r < 4; r++) begin
                pend_cnt_q[r] <= '0;
            end
        end else begin
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            count_q    <= count_d;
            sb_err_q   <= sb_err_d;
            pend_cnt_q <= pend_cnt_d;
        end
    end

    // Storage needs no reset: only entries between the pointers are visible.
    always_ff @(posedge clk) begin
        reg_mem_q  <= reg_mem_d;
        data_mem_q <= data_mem_d;
    end

endmodule
`default_nettype wire

// File: tb/tb_regfile_write_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_regfile_write_ctrl
//  Purpose  : Self-checking bench for regfile_write_ctrl: directed vector
//             table, hand-written multi-cycle sequences and random traffic
//             compared against a queue/integer reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_regfile_write_ctrl;

    localparam int DEPTH = 4;
    localparam int CNTW  = 3;
    localparam int CMAX  = (1 << CNTW) - 1;

    logic        clk = 1'b0;
    logic        reset, req_valid, req_ready, rsv_valid, rsv_ready, wr_hold;
    logic [1:0]  req_reg, rsv_reg, WriteReg;
    logic [31:0] req_data, WriteData;
    logic        RegWrite, sb_err;
    logic [3:0]  busy_mask;

    regfile_write_ctrl #(.DEPTH(DEPTH), .CNTW(CNTW)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_reg(req_reg), .req_data(req_data),
        .rsv_valid(rsv_valid), .rsv_ready(rsv_ready), .rsv_reg(rsv_reg),
        .wr_hold(wr_hold),
        .RegWrite(RegWrite), .WriteReg(WriteReg), .WriteData(WriteData),
        .busy_mask(busy_mask), .sb_err(sb_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: FIFO as a queue, scoreboard as plain integers
    typedef struct { logic [1:0] r; logic [31:0] d; } ent_t;
    ent_t mq[$];
    int   pend[4];
    logic merr;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_check();
        int          n;
        logic [1:0]  e_wr;
        logic [31:0] e_wd;
        logic [3:0]  e_busy;
        n    = mq.size();
        e_wr = 2'd0;
        e_wd = 32'd0;
        if (!reset && n != 0) begin
            e_wr = mq[0].r;
            e_wd = mq[0].d;
        end
        for (int r = 0; r < 4; r++) e_busy[r] = !reset && (pend[r] != 0);
        chk("req_ready", req_ready, !reset && (n != DEPTH));
        chk("RegWrite",  RegWrite,  !reset && (n != 0) && !wr_hold);
        chk("WriteReg",  WriteReg,  e_wr);
        chk("WriteData", WriteData, e_wd);
        chk("busy_mask", busy_mask, e_busy);
        chk("rsv_ready", rsv_ready, !reset && (pend[rsv_reg] != CMAX));
        chk("sb_err",    sb_err,    merr);
    endtask

    task automatic model_update();
        bit push, pop, rsv;
        int nc;
        if (reset) begin
            mq.delete();
            for (int r = 0; r < 4; r++) pend[r] = 0;
            merr = 1'b0;
            return;
        end
        push = req_valid && (mq.size() != DEPTH);
        pop  = (mq.size() != 0) && !wr_hold;
        rsv  = rsv_valid && (pend[rsv_reg] != CMAX);
        for (int r = 0; r < 4; r++) begin
            nc = pend[r];
            if (rsv && rsv_reg == 2'(r)) nc = nc + 1;
            if (pop && mq[0].r == 2'(r)) nc = nc - 1;
            if (nc < 0) begin
                merr = 1'b1;
                nc   = 0;
            end
            pend[r] = nc;
        end
        if (pop)  mq.delete(0);
        if (push) mq.push_back('{req_reg, req_data});
    endtask

    // Drive inputs (at the falling edge) and check outputs 1 ns later.
    task automatic apply(input logic rst, input logic rv, input logic [1:0] rr,
                         input logic [31:0] rd, input logic sv, input logic [1:0] sr,
                         input logic h);
        reset = rst; req_valid = rv; req_reg = rr; req_data = rd;
        rsv_valid = sv; rsv_reg = sr; wr_hold = h;
        #1;
        model_check();
    endtask

    task automatic tick();
        model_update();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic step(input logic rst, input logic rv, input logic [1:0] rr,
                        input logic [31:0] rd, input logic sv, input logic [1:0] sr,
                        input logic h);
        apply(rst, rv, rr, rd, sv, sr, h);
        tick();
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 2'd0, 32'd0, 1'b0, 2'd0, 1'b0);
    endtask

    task automatic do_reset();
        step(1'b1, 1'b0, 2'd0, 32'd0, 1'b0, 2'd0, 1'b0);
    endtask

    // Directed vector table: inputs plus hand-derived expected outputs
    typedef struct {
        logic        rst, rv;
        logic [1:0]  rr;
        logic [31:0] rd;
        logic        sv;
        logic [1:0]  sr;
        logic        h;
        logic        e_rr, e_rw;
        logic [1:0]  e_wr;
        logic [31:0] e_wd;
        logic [3:0]  e_busy;
    } vec_t;

    vec_t vecs[15];

    logic [31:0] commit_log[$];
    logic [31:0] exp_log[$];

    initial begin
        // Single write: reserve r2, push r2, observe commit and busy clearing
        vecs[0]  = '{1'b1, 1'b0, 2'd0, 32'h0,        1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 2'd0, 32'h0,        4'b0000};
        vecs[1]  = '{1'b0, 1'b0, 2'd0, 32'h0,        1'b1, 2'd2, 1'b0, 1'b1, 1'b0, 2'd0, 32'h0,        4'b0000};
        vecs[2]  = '{1'b0, 1'b1, 2'd2, 32'hDEADBEEF, 1'b0, 2'd0, 1'b0, 1'b1, 1'b0, 2'd0, 32'h0,        4'b0100};
        vecs[3]  = '{1'b0, 1'b0, 2'd0, 32'h0,        1'b0, 2'd0, 1'b0, 1'b1, 1'b1, 2'd2, 32'hDEADBEEF, 4'b0100};
        vecs[4]  = '{1'b0, 1'b0, 2'd0, 32'h0,        1'b0, 2'd0, 1'b0, 1'b1, 1'b0, 2'd0, 32'h0,        4'b0000};
        // Fill with wr_hold=1, refused 5th push, then in-order drain
        vecs[5]  = '{1'b0, 1'b1, 2'd0, 32'h10,       1'b0, 2'd0, 1'b1, 1'b1, 1'b0, 2'd0, 32'h0,        4'b0000};
        vecs[6]  = '{1'b0, 1'b1, 2'd1, 32'h11,       1'b0, 2'd0, 1'b1, 1'b1, 1'b0, 2'd0, 32'h10,       4'b0000};
        vecs[7]  = '{1'b0, 1'b1, 2'd2, 32'h12,       1'b0, 2'd0, 1'b1, 1'b1, 1'b0, 2'd0, 32'h10,       4'b0000};
        vecs[8]  = '{1'b0, 1'b1, 2'd3, 32'h13,       1'b0, 2'd0, 1'b1, 1'b1, 1'b0, 2'd0, 32'h10,       4'b0000};
        vecs[9]  = '{1'b0, 1'b1, 2'd0, 32'h99,       1'b0, 2'd0, 1'b1, 1'b0, 1'b0, 2'd0, 32'h10,       4'b0000};
        vecs[10] = '{1'b0, 1'b0, 2'd0, 32'h0,        1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 2'd0, 32'h10,       4'b0000};
        vecs[11] = '{1'b0, 1'b0, 2'd0, 32'h0,        1'b0, 2'd0, 1'b0, 1'b1, 1'b1, 2'd1, 32'h11,       4'b0000};
        vecs[12] = '{1'b0, 1'b0, 2'd0, 32'h0,        1'b0, 2'd0, 1'b0, 1'b1, 1'b1, 2'd2, 32'h12,       4'b0000};
        vecs[13] = '{1'b0, 1'b0, 2'd0, 32'h0,        1'b0, 2'd0, 1'b0, 1'b1, 1'b1, 2'd3, 32'h13,       4'b0000};
        vecs[14] = '{1'b0, 1'b0, 2'd0, 32'h0,        1'b0, 2'd0, 1'b0, 1'b1, 1'b0, 2'd0, 32'h0,        4'b0000};

        // Initial reset without checks: DUT state is unknown before it
        reset = 1'b1; req_valid = 1'b0; req_reg = 2'd0; req_data = 32'd0;
        rsv_valid = 1'b0; rsv_reg = 2'd0; wr_hold = 1'b0;
        mq.delete();
        for (int r = 0; r < 4; r++) pend[r] = 0;
        merr = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);

        // ---------------- Vector table ----------------
        for (int i = 0; i < 15; i++) begin
            apply(vecs[i].rst, vecs[i].rv, vecs[i].rr, vecs[i].rd,
                  vecs[i].sv, vecs[i].sr, vecs[i].h);
            chk($sformatf("vec%0d_req_ready", i), req_ready, vecs[i].e_rr);
            chk($sformatf("vec%0d_RegWrite", i),  RegWrite,  vecs[i].e_rw);
            chk($sformatf("vec%0d_WriteReg", i),  WriteReg,  vecs[i].e_wr);
            chk($sformatf("vec%0d_WriteData", i), WriteData, vecs[i].e_wd);
            chk($sformatf("vec%0d_busy_mask", i), busy_mask, vecs[i].e_busy);
            tick();
        end

        // ---------------- Push/pop at full across the wrap ----------------
        do_reset();
        for (int i = 0; i < DEPTH; i++) begin
            step(1'b0, 1'b1, 2'(i), 32'h100 + i, 1'b0, 2'd0, 1'b1);
            exp_log.push_back(32'h100 + i);
        end
        begin
            logic [31:0] nd;
            nd = 32'h200;
            commit_log.delete();
            for (int k = 0; k < 10; k++) begin
                apply(1'b0, 1'b1, nd[1:0], nd, 1'b0, 2'd0, 1'b0);
                if (k == 0) chk("full_no_lookahead", req_ready, 1'b0);
                if (k == 1) chk("ready_after_pop", req_ready, 1'b1);
                if (RegWrite) commit_log.push_back(WriteData);
                if (req_ready) begin
                    exp_log.push_back(nd);
                    nd = nd + 1;
                end
                tick();
            end
            for (int k = 0; k < DEPTH + 1; k++) begin
                apply(1'b0, 1'b0, 2'd0, 32'd0, 1'b0, 2'd0, 1'b0);
                if (RegWrite) commit_log.push_back(WriteData);
                tick();
            end
            chk("wrap_commit_count", commit_log.size(), exp_log.size());
            for (int k = 0; k < commit_log.size() && k < exp_log.size(); k++)
                chk($sformatf("wrap_order%0d", k), commit_log[k], exp_log[k]);
        end

        // ---------------- Scoreboard saturation / same-cycle / underflow ----------------
        do_reset();
        apply(1'b0, 1'b0, 2'd0, 32'd0, 1'b0, 2'd0, 1'b0);
        chk("sb_err_after_reset", sb_err, 1'b0);
        tick();
        for (int i = 0; i < 7; i++) step(1'b0, 1'b0, 2'd0, 32'd0, 1'b1, 2'd1, 1'b0);
        apply(1'b0, 1'b0, 2'd0, 32'd0, 1'b1, 2'd1, 1'b0);
        chk("rsv_8th_refused", rsv_ready, 1'b0);
        tick();
        step(1'b0, 1'b1, 2'd1, 32'hA1, 1'b0, 2'd0, 1'b1);
        step(1'b0, 1'b1, 2'd1, 32'hA2, 1'b0, 2'd0, 1'b1);
        step(1'b0, 1'b0, 2'd0, 32'd0, 1'b0, 2'd1, 1'b0);          // commit A1: 7 -> 6
        apply(1'b0, 1'b0, 2'd0, 32'd0, 1'b1, 2'd1, 1'b0);         // commit A2 + rsv r1
        chk("same_cycle_rsv_ready", rsv_ready, 1'b1);
        chk("same_cycle_commit_r1", WriteReg, 2'd1);
        tick();
        apply(1'b0, 1'b0, 2'd0, 32'd0, 1'b1, 2'd1, 1'b0);         // count still 6
        chk("count_unchanged_6", rsv_ready, 1'b1);
        tick();
        apply(1'b0, 1'b0, 2'd0, 32'd0, 1'b0, 2'd1, 1'b0);         // now 7
        chk("count_back_to_7", rsv_ready, 1'b0);
        chk("busy_r1_only", busy_mask, 4'b0010);
        tick();
        step(1'b0, 1'b1, 2'd3, 32'h33, 1'b0, 2'd0, 1'b0);
        idle();                                                   // commit r3 with pend 0
        for (int i = 0; i < 3; i++) begin
            apply(1'b0, 1'b0, 2'd0, 32'd0, 1'b0, 2'd0, 1'b0);
            chk($sformatf("sb_err_sticky%0d", i), sb_err, 1'b1);
            tick();
        end
        do_reset();
        apply(1'b0, 1'b0, 2'd0, 32'd0, 1'b0, 2'd0, 1'b0);
        chk("sb_err_cleared", sb_err, 1'b0);
        tick();

        // ---------------- Reset mid-operation ----------------
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 2'(i), 32'h500 + i, 1'b1, 2'(i), 1'b1);
        apply(1'b1, 1'b0, 2'd0, 32'd0, 1'b0, 2'd0, 1'b0);
        chk("regwrite_in_reset", RegWrite, 1'b0);
        chk("req_ready_in_reset", req_ready, 1'b0);
        tick();
        apply(1'b0, 1'b0, 2'd0, 32'd0, 1'b0, 2'd0, 1'b0);
        chk("post_reset_req_ready", req_ready, 1'b1);
        chk("post_reset_busy", busy_mask, 4'b0000);
        chk("post_reset_sb_err", sb_err, 1'b0);
        chk("post_reset_no_stale", RegWrite, 1'b0);
        tick();
        for (int i = 0; i < 3; i++) begin
            apply(1'b0, 1'b0, 2'd0, 32'd0, 1'b0, 2'd0, 1'b0);
            chk($sformatf("no_stale_write%0d", i), RegWrite, 1'b0);
            tick();
        end

        // ---------------- Randomized traffic vs reference model ----------------
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 99) < 2,
                 $urandom_range(0, 99) < 60,
                 2'($urandom_range(0, 3)),
                 $urandom,
                 $urandom_range(0, 99) < 50,
                 2'($urandom_range(0, 3)),
                 $urandom_range(0, 99) < 30);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
